mem_system: RTL and testbench
=============================

Name: mem_system

Overview:
- Memory subsystem directly downstream of the CPU; consumes the CPU's mem_cmd, mem_addr and write data, and returns read_data.
- Contains:
  - a 2^RAM_AW x DATA_W synchronous RAM;
  - a memory-mapped LED output register;
  - a memory-mapped, synchronised switch input.
- After every reset, a clear sequencer zeroes the RAM, then raises mem_ready.
- Top level holds the CPU in reset until mem_ready=1.

Parameters:
- DATA_W, 16: word width.
- RAM_AW, 8: RAM address bits; depth = 2^RAM_AW words, mapped at 0 .. 2^RAM_AW-1.
- LED_ADDR, 9'h100: write address of the LED register.
- SW_ADDR, 9'h140: read address of the switch input.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- mem_cmd  input  2  command: 2'b00 MNONE, 2'b01 MREAD, 2'b10 MWRITE, 2'b11 treated as MNONE.
- mem_addr  input  9  word address from CPU.
- write_data  input  DATA_W  store data (CPU datapath output).
- read_data  output  DATA_W  registered load data to CPU.
- SW  input  8  board switches, asynchronous to clk.
- LEDR  output  8  board LEDs.
- mem_ready  output  1  high once the RAM clear sweep is done.

Behaviour:
- Reset (reset=0, asynchronous):
  - state<=CLEAR, clr_addr<=0, read_data<=0, LEDR<=0, mem_ready<=0, both switch-sync flops <=0.
  - RAM contents are not reset directly; they are cleared only by the sweep.
- FSM, 2 states:
  - CLEAR: each clk edge writes 0 to mem[clr_addr], then clr_addr<=clr_addr+1. On the edge writing address 2^RAM_AW-1, go to READY. Sweep lasts exactly 2^RAM_AW cycles after reset release.
  - READY: mem_ready=1. Stays until reset is asserted.
  - Reset mid-sweep restarts the sweep at address 0.
  - In CLEAR, all mem_cmd values are ignored: no RAM/LED writes, read_data holds 0.
- Address decode (READY only):
  - RAM hit = mem_addr[8:RAM_AW]==0.
  - LED hit = mem_addr==LED_ADDR.
  - SW hit = mem_addr==SW_ADDR.
- MWRITE at rising edge:
  - RAM hit: mem[mem_addr[RAM_AW-1:0]] <= write_data.
  - LED hit: LEDR <= write_data[7:0].
  - Any other address: write discarded, no side effects.
- MREAD at rising edge, read_data loaded as follows:
  - RAM hit: mem[addr], using the old value if written the same cycle; no write happens on MREAD.
  - SW hit: {8'h00, sw_sync}.
  - Otherwise: 16'h0000.
- Read latency: 1 cycle. Data is valid the cycle after the edge that sampled MREAD. The CPU holds MREAD/address for ≥1 edge before loading.
- MNONE or 2'b11: read_data holds its last value; no state change.
- Switch path: 2-flop synchroniser on SW, sw_sync = second flop. A switch change is visible to a read 2 edges after it is sampled.
- Address width: mem_addr is always 9 bits; bits above RAM_AW are used only for decode.

Optional Feature:
- Macro: MEM_SYSTEM_STATS_EN.
- When defined, adds two output ports:
  - rd_count[15:0]: +1 per MREAD accepted in READY.
  - wr_count[15:0]: +1 per MWRITE accepted in READY, including discarded unmapped writes.
- Both counters saturate at 16'hFFFF, reset to 0, and do not count during CLEAR.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Clear sweep: release reset, drive MWRITE addr 0 data 16'hBEEF throughout. Required: mem_ready=0 for exactly 256 cycles, then 1. A subsequent MREAD of addr 0 returns 16'h0000. The CLEAR-time write is ignored.
- RAM store/load: MWRITE 9'h005 data 16'h1234, then MREAD 9'h005. Required: read_data=16'h1234 one cycle after the read edge. MREAD of 9'h0FF returns 0.
- LED write: MWRITE 9'h100 data 16'hABCD. Required: LEDR=8'hCD after the edge. MWRITE 9'h1FF leaves LEDR and RAM unchanged.
- Switch read: SW=8'h5A, wait 2 cycles, MREAD 9'h140. Required: read_data=16'h005A. MREAD 9'h150 returns 16'h0000.
- Hold/reset:
  - MREAD 9'h005, then MNONE for 3 cycles: read_data stays 16'h1234.
  - Assert reset mid-sweep at cycle 100: read_data=0, LEDR=0, mem_ready=0 immediately. After release, the sweep restarts and lasts 256 cycles.
- Stats (MEM_SYSTEM_STATS_EN): 3 MREADs + 2 MWRITEs in READY give rd_count=3, wr_count=2. Commands issued during CLEAR leave both counters at 0.

Source files
------------

// File: rtl/mem_system.sv
// Memory subsystem: RAM with a post-reset clear sweep, LED register and synchronised switch input.
// Optional access counters are enabled by defining MEM_SYSTEM_STATS_EN.
//
// state  | meaning
// CLEAR  | sweeping zeros into the RAM, CPU commands ignored
// READY  | mem_ready high, CPU commands serviced
module mem_system #(
    parameter int         DATA_W   = 16,
    parameter int         RAM_AW   = 8,
    parameter logic [8:0] LED_ADDR = 9'h100,
    parameter logic [8:0] SW_ADDR  = 9'h140
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mem_cmd,
    input  logic [8:0]        mem_addr,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] read_data,
    input  logic [7:0]        SW,
    output logic [7:0]        LEDR,
`ifdef MEM_SYSTEM_STATS_EN
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count,
`endif
    output logic              mem_ready
);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    logic [DATA_W-1:0] mem [2**RAM_AW];

    logic [0:0]        state_q, state_d;
    logic [RAM_AW-1:0] clr_addr_q, clr_addr_d;
    logic [DATA_W-1:0] read_data_q, read_data_d;
    logic [7:0]        ledr_q, ledr_d;
    logic [7:0]        sw_meta_q, sw_meta_d;
    logic [7:0]        sw_sync_q, sw_sync_d;

    logic              mem_we;
    logic [RAM_AW-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;

    logic              ram_hit, led_hit, sw_hit;
    logic              cmd_read, cmd_write;
    logic [RAM_AW-1:0] ram_idx;

    assign ram_hit   = (mem_addr[8:RAM_AW] == '0);
    assign led_hit   = (mem_addr == LED_ADDR);
    assign sw_hit    = (mem_addr == SW_ADDR);
    assign ram_idx   = mem_addr[RAM_AW-1:0];
    assign cmd_read  = (state_q == ST_READY) && (mem_cmd == MREAD);
    assign cmd_write = (state_q == ST_READY) && (mem_cmd == MWRITE);

    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        read_data_d = read_data_q;
        ledr_d      = ledr_q;
        sw_meta_d   = SW;
        sw_sync_d   = sw_meta_q;
        mem_we      = 1'b0;
        mem_wa      = clr_addr_q;
        mem_wd      = '0;
        case (state_q)
            ST_CLEAR: begin
                mem_we     = 1'b1;
                clr_addr_d = clr_addr_q + RAM_AW'(1);
                if (clr_addr_q == {RAM_AW{1'b1}}) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                if (cmd_write) begin
                    if (ram_hit) begin
                        mem_we = 1'b1;
                        mem_wa = ram_idx;
                        mem_wd = write_data;
                    end
                    if (led_hit) begin
                        ledr_d = write_data[7:0];
                    end
                end else if (cmd_read) begin
                    if (ram_hit) begin
                        read_data_d = mem[ram_idx];
                    end else if (sw_hit) begin
                        read_data_d = {{(DATA_W-8){1'b0}}, sw_sync_q};
                    end else begin
                        read_data_d = '0;
                    end
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_CLEAR;
            clr_addr_q  <= '0;
            read_data_q <= '0;
            ledr_q      <= '0;
            sw_meta_q   <= '0;
            sw_sync_q   <= '0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            read_data_q <= read_data_d;
            ledr_q      <= ledr_d;
            sw_meta_q   <= sw_meta_d;
            sw_sync_q   <= sw_sync_d;
        end
    end

    // RAM array has no reset; the CLEAR sweep zeroes it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

`ifdef MEM_SYSTEM_STATS_EN
    logic [15:0] rd_count_q, rd_count_d;
    logic [15:0] wr_count_q, wr_count_d;

    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (cmd_read && (rd_count_q != 16'hFFFF)) begin
            rd_count_d = rd_count_q + 16'd1;
        end
        if (cmd_write && (wr_count_q != 16'hFFFF)) begin
            wr_count_d = wr_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`endif

    assign read_data = read_data_q;
    assign LEDR      = ledr_q;
    assign mem_ready = (state_q == ST_READY);

endmodule

// File: tb/tb_mem_system.sv
// Randomised bench for mem_system against a word-array reference model.
// Counter ports are checked when MEM_SYSTEM_STATS_EN is defined.
module tb_mem_system;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  mem_cmd = 2'b00;
    logic [8:0]  mem_addr = 9'h000;
    logic [15:0] write_data = 16'h0000;
    logic [15:0] read_data;
    logic [7:0]  SW = 8'h00;
    logic [7:0]  LEDR;
    logic        mem_ready;
`ifdef MEM_SYSTEM_STATS_EN
    logic [15:0] rd_count, wr_count;
`endif

    mem_system dut (
        .clk        (clk),
        .reset      (reset),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .read_data  (read_data),
        .SW         (SW),
        .LEDR       (LEDR),
`ifdef MEM_SYSTEM_STATS_EN
        .rd_count   (rd_count),
        .wr_count   (wr_count),
`endif
        .mem_ready  (mem_ready)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [15:0] m_mem [256];
    logic [15:0] m_rd;
    logic [7:0]  m_led;
    logic [7:0]  sw_seen [$];
    int          m_edges;
    int          m_rdc, m_wrc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (m_mem[i]) m_mem[i] = 16'h0000;
        m_rd    = 16'h0000;
        m_led   = 8'h00;
        m_edges = 0;
        m_rdc   = 0;
        m_wrc   = 0;
        sw_seen.delete();
    endtask

    // One rising edge with the inputs currently driven; model then compare.
    task automatic step();
        logic [7:0] sw_vis;
        bit         ready;
        ready  = (m_edges >= 256);
        sw_vis = (sw_seen.size() >= 2) ? sw_seen[sw_seen.size()-2] : 8'h00;
        sw_seen.push_back(SW);
        if (ready) begin
            if (mem_cmd == 2'b10) begin
                if (mem_addr < 9'd256) m_mem[mem_addr[7:0]] = write_data;
                if (mem_addr == 9'h100) m_led = write_data[7:0];
                m_wrc = (m_wrc < 65535) ? m_wrc + 1 : m_wrc;
            end else if (mem_cmd == 2'b01) begin
                if (mem_addr < 9'd256)       m_rd = m_mem[mem_addr[7:0]];
                else if (mem_addr == 9'h140) m_rd = {8'h00, sw_vis};
                else                         m_rd = 16'h0000;
                m_rdc = (m_rdc < 65535) ? m_rdc + 1 : m_rdc;
            end
        end
        m_edges++;
        @(posedge clk);
        #1;
        chk("read_data", read_data, m_rd);
        chk("ledr", LEDR, m_led);
        chk("mem_ready", mem_ready, m_edges >= 256);
`ifdef MEM_SYSTEM_STATS_EN
        chk("rd_count", rd_count, m_rdc);
        chk("wr_count", wr_count, m_wrc);
`endif
    endtask

    task automatic op(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
        mem_cmd    = c;
        mem_addr   = a;
        write_data = d;
        step();
    endtask

    task automatic sweep_check(input string tag);
        int n = 0;
        while (!mem_ready && n < 400) begin
            step();
            n++;
        end
        chk(tag, n, 256);
    endtask

    task automatic assert_reset();
        reset = 1'b0;
        model_reset();
        #1;
        chk("rst_read_data", read_data, 16'h0000);
        chk("rst_ledr", LEDR, 8'h00);
        chk("rst_mem_ready", mem_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        model_reset();
        #12;
        chk("rst_read_data", read_data, 16'h0000);
        chk("rst_ledr", LEDR, 8'h00);
        chk("rst_mem_ready", mem_ready, 1'b0);
        @(posedge clk);
        #1;
        reset      = 1'b1;
        mem_cmd    = 2'b10;
        mem_addr   = 9'h000;
        write_data = 16'hBEEF;
        sweep_check("sweep_len");

        op(2'b01, 9'h000, 16'h0);
        chk("clear_rd0", read_data, 16'h0000);
        op(2'b10, 9'h005, 16'h1234);
        op(2'b01, 9'h005, 16'h0);
        chk("rd5", read_data, 16'h1234);
        repeat (3) begin
            op(2'b00, 9'h005, 16'hFFFF);
            chk("hold_mnone", read_data, 16'h1234);
        end
        op(2'b11, 9'h000, 16'hFFFF);
        chk("hold_cmd3", read_data, 16'h1234);
        op(2'b01, 9'h0FF, 16'h0);
        chk("rd_ff", read_data, 16'h0000);
        op(2'b10, 9'h100, 16'hABCD);
        chk("led_wr", LEDR, 8'hCD);
        op(2'b10, 9'h1FF, 16'h7777);
        chk("unmapped_led", LEDR, 8'hCD);
        op(2'b01, 9'h0FF, 16'h0);
        chk("unmapped_ram", read_data, 16'h0000);
        SW = 8'h5A;
        op(2'b00, 9'h000, 16'h0);
        op(2'b00, 9'h000, 16'h0);
        op(2'b01, 9'h140, 16'h0);
        chk("sw_rd", read_data, 16'h005A);
        op(2'b01, 9'h150, 16'h0);
        chk("rd_150", read_data, 16'h0000);

        for (int i = 0; i < 1500; i++) begin
            logic [8:0] a;
            case ($urandom_range(0, 5))
                0, 1, 2: a = 9'($urandom_range(0, 15));
                3:       a = 9'h100;
                4:       a = 9'h140;
                default: a = 9'($urandom);
            endcase
            if ($urandom_range(0, 7) == 0) SW = 8'($urandom);
            op(2'($urandom_range(0, 3)), a, 16'($urandom));
        end

        op(2'b10, 9'h100, 16'h00C3);
        op(2'b10, 9'h005, 16'h4321);
        op(2'b01, 9'h005, 16'h0);
        chk("pre_reset_rd", read_data, 16'h4321);
        assert_reset();
        mem_cmd  = 2'b10;
        mem_addr = 9'h100;
        write_data = 16'h00FF;
        repeat (100) step();
        assert_reset();
        mem_cmd  = 2'b01;
        mem_addr = 9'h005;
        sweep_check("sweep_restart");
        op(2'b01, 9'h005, 16'h0);
        chk("rd5_cleared", read_data, 16'h0000);
`ifdef MEM_SYSTEM_STATS_EN
        chk("rd_count_clear", rd_count, 16'd1);
        chk("wr_count_clear", wr_count, 16'd0);
        assert_reset();
        mem_cmd = 2'b10;
        sweep_check("sweep_stats");
        chk("rd_count_sweep", rd_count, 16'd0);
        chk("wr_count_sweep", wr_count, 16'd0);
        op(2'b01, 9'h001, 16'h0);
        op(2'b10, 9'h002, 16'h1111);
        op(2'b01, 9'h140, 16'h0);
        op(2'b10, 9'h1FF, 16'h2222);
        op(2'b01, 9'h150, 16'h0);
        op(2'b00, 9'h000, 16'h0);
        chk("rd_count3", rd_count, 16'd3);
        chk("wr_count2", wr_count, 16'd2);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
